// File: rtl/ssp_pkg.sv
// Shared SSP definitions: transmit/receive state encoding, minimum legal data
// size and default datapath parameters. Used by the TX serializer and the RX
// deserializer.
package ssp_pkg;

    // Serializer control states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } ssp_state_t;

    // Smallest legal DSS code (4-bit frames); codes 0..2 are reserved
    localparam logic [3:0] DSS_MIN = 4'd3;

    // Width of the bit counter (DSS code width)
    localparam int CNT_W = 4;

    // Default justified word width and FIFO/justifier settle latency
    localparam int SSP_DATA_W = 16;
    localparam int SSP_SETTLE = 2;

endpackage

// File: rtl/ssp_tx_bitcnt.sv
// Loadable down-counter tracking the remaining bits of the current frame.
// Decrements once per serial bit strobe while the frame is active and reports
// when the final bit is on the line.
module ssp_tx_bitcnt
    import ssp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             active,
    input  logic             sclk_en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority; otherwise count down one per active bit strobe, holding at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (active && sclk_en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ssp_tx_shifter.sv
// SSP transmit serializer. Pops one left-justified word from the TX FIFO,
// shifts DSSPCLK+1 bits out MSB first on SSPTXD (one bit per SclkEn) and frames
// them with active-low SSPFSSOUT.
// Build option: define SSP_TX_CONT_EN for continuous mode, where the next word
// is reloaded on the last bit strobe and frames run back to back with FSS held
// low. Without it every frame ends through a one-bit-period gap with FSS high.
module ssp_tx_shifter
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int SETTLE = SSP_SETTLE
)
(
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              SSE,
    input  logic [3:0]        DSSPCLK,
    input  logic [DATA_W-1:0] TxFRdDataIn,
    input  logic              TxFEmpty,
    input  logic              SclkEn,
    output logic              TxFRd,
    output logic              SSPTXD,
    output logic              SSPFSSOUT,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int            SW         = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);

    ssp_state_t        state;
    logic [DATA_W-1:0] shreg;
    logic [SW-1:0]     settle_cnt;

    logic settled;
    logic dss_ok;
    logic can_load;
    logic shifting;
    logic bit_zero;
    logic last_bit;
    logic cont_reload;
    logic word_load;
    logic shift_adv;

    assign settled  = (settle_cnt == SETTLE_MAX);
    assign dss_ok   = (DSSPCLK >= DSS_MIN);
    assign can_load = SSE && !TxFEmpty && settled && dss_ok;
    assign shifting = SSE && (state == ST_SHIFT);
    assign last_bit = shifting && SclkEn && bit_zero;

`ifdef SSP_TX_CONT_EN
    // Reserved DSS codes are also refused here so they never cause a pop
    assign cont_reload = last_bit && can_load;
`else
    assign cont_reload = 1'b0;
`endif

    assign word_load = (SSE && (state == ST_LOAD)) || cont_reload;
    assign shift_adv = shifting && SclkEn && !bit_zero;

    ssp_tx_bitcnt u_bitcnt (
        .clk      (PCLK),
        .rst      (PRESET),
        .load     (word_load),
        .load_val (DSSPCLK),
        .active   (shifting),
        .sclk_en  (SclkEn),
        .zero     (bit_zero)
    );

    // Counts PCLK cycles since the last pop so a word is never taken before the FIFO/justifier output settles
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            settle_cnt <= SETTLE_MAX;
        end else if (TxFRd) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    // Shift register: captures the justified word on load, shifts left (zero fill) per consumed bit
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            shreg <= '0;
        end else if (word_load) begin
            shreg <= TxFRdDataIn;
        end else if (shift_adv) begin
            shreg <= shreg << 1;
        end
    end

    // Frame control FSM with registered pop strobe, serial data, frame select and status outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            TxFRd     <= 1'b0;
            SSPTXD    <= 1'b0;
            SSPFSSOUT <= 1'b1;
            TxBusy    <= 1'b0;
            TxDone    <= 1'b0;
        end else begin
            TxFRd  <= 1'b0;
            TxDone <= 1'b0;
            if (!SSE) begin
                state     <= ST_IDLE;
                SSPTXD    <= 1'b0;
                SSPFSSOUT <= 1'b1;
                TxBusy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (can_load) begin
                            state  <= ST_LOAD;
                            TxFRd  <= 1'b1;
                            TxBusy <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        // SclkEn here is deliberately ignored; first bit goes out next cycle
                        state     <= ST_SHIFT;
                        SSPFSSOUT <= 1'b0;
                        SSPTXD    <= TxFRdDataIn[DATA_W-1];
                    end
                    ST_SHIFT: begin
                        if (SclkEn) begin
                            if (!bit_zero) begin
                                SSPTXD <= shreg[DATA_W-2];
                            end else if (cont_reload) begin
                                TxDone <= 1'b1;
                                TxFRd  <= 1'b1;
                                SSPTXD <= TxFRdDataIn[DATA_W-1];
                            end else begin
                                TxDone    <= 1'b1;
                                state     <= ST_GAP;
                                SSPFSSOUT <= 1'b1;
                                SSPTXD    <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (SclkEn) begin
                            state  <= ST_IDLE;
                            TxBusy <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssp_tx_shifter.sv
// Directed bench for ssp_tx_shifter. A small FIFO model supplies justified
// words (invalid for one cycle after each pop), SclkEn strobes every 4 PCLK
// cycles, and a per-cycle monitor collects popped words, done pulses, FSS
// rising edges and the bits presented on each strobe while FSS is low.
module tb_ssp_tx_shifter;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        SSE;
    logic [3:0]  DSSPCLK;
    logic [15:0] TxFRdDataIn;
    logic        TxFEmpty;
    logic        SclkEn;
    logic        TxFRd;
    logic        SSPTXD;
    logic        SSPFSSOUT;
    logic        TxBusy;
    logic        TxDone;

    int vecs = 0;
    int errs = 0;

    logic [15:0] fifo[$];
    logic        bitq[$];
    int          cyc = 0;
    int          pop_cnt = 0;
    int          done_cnt = 0;
    int          rise_cnt = 0;
    int          strobes = 0;
    bit          pend_pop = 1'b0;
    bit          data_bad = 1'b0;
    logic        prev_fss = 1'b1;

    ssp_tx_shifter dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .SSE         (SSE),
        .DSSPCLK     (DSSPCLK),
        .TxFRdDataIn (TxFRdDataIn),
        .TxFEmpty    (TxFEmpty),
        .SclkEn      (SclkEn),
        .TxFRd       (TxFRd),
        .SSPTXD      (SSPTXD),
        .SSPFSSOUT   (SSPFSSOUT),
        .TxBusy      (TxBusy),
        .TxDone      (TxDone)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_fifo();
        TxFEmpty    = (fifo.size() == 0);
        TxFRdDataIn = data_bad ? 16'hFFFF : ((fifo.size() == 0) ? 16'h0000 : fifo[0]);
    endtask

    task automatic clr();
        pop_cnt  = 0;
        done_cnt = 0;
        rise_cnt = 0;
        strobes  = 0;
        bitq.delete();
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
        cyc++;
        data_bad = 1'b0;
        if (pend_pop) begin
            pend_pop = 1'b0;
            if (fifo.size() > 0) void'(fifo.pop_front());
            data_bad = 1'b1;
        end
        if (TxFRd === 1'b1) begin
            pop_cnt++;
            pend_pop = 1'b1;
        end
        if (TxDone === 1'b1) done_cnt++;
        if (SSPFSSOUT === 1'b1 && prev_fss === 1'b0) rise_cnt++;
        prev_fss = SSPFSSOUT;
        SclkEn = (cyc % 4 == 0);
        if (SclkEn && SSPFSSOUT === 1'b0) begin
            bitq.push_back(SSPTXD);
            strobes++;
        end
        drive_fifo();
    endtask

    function automatic logic [31:0] packed_bits();
        logic [31:0] v = '0;
        for (int i = 0; i < bitq.size(); i++) v = {v[30:0], bitq[i]};
        return v;
    endfunction

    task automatic test_reset();
        PRESET = 1'b1;
        SSE = 1'b0;
        DSSPCLK = 4'd7;
        SclkEn = 1'b0;
        drive_fifo();
        repeat (3) step();
        vecs++;
        if ({TxFRd, SSPTXD, SSPFSSOUT, TxBusy, TxDone} !== 5'b00100) begin
            errs++;
            $display("FAIL reset_outputs: got %b expected 00100", {TxFRd, SSPTXD, SSPFSSOUT, TxBusy, TxDone});
        end
        PRESET = 1'b0;
        prev_fss = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int gap;
        clr();
        DSSPCLK = 4'd7;
        fifo.push_back(16'hA500);
        drive_fifo();
        SSE = 1'b1;
        for (int i = 0; i < 300 && done_cnt == 0; i++) step();
        vecs++;
        if (done_cnt !== 1) begin
            errs++;
            $display("FAIL t1_done: got %0d expected 1", done_cnt);
        end
        vecs++;
        if ({SSPFSSOUT, TxBusy, SSPTXD} !== 3'b110) begin
            errs++;
            $display("FAIL t1_gap_state: fss/busy/txd got %b expected 110", {SSPFSSOUT, TxBusy, SSPTXD});
        end
        vecs++;
        if (bitq.size() != 8) begin
            errs++;
            $display("FAIL t1_bitcount: got %0d expected 8", bitq.size());
        end
        vecs++;
        if (packed_bits() !== 32'h0000_00A5) begin
            errs++;
            $display("FAIL t1_bits: got %h expected 000000a5", packed_bits());
        end
        gap = 0;
        for (int i = 0; i < 10 && TxBusy === 1'b1; i++) begin
            step();
            gap++;
        end
        vecs++;
        if (gap != 4) begin
            errs++;
            $display("FAIL t1_gap_len: got %0d cycles expected 4", gap);
        end
        repeat (20) step();
        vecs++;
        if (pop_cnt != 1 || done_cnt != 1 || SSPFSSOUT !== 1'b1) begin
            errs++;
            $display("FAIL t1_after: pops %0d done %0d fss %b expected 1 1 1", pop_cnt, done_cnt, SSPFSSOUT);
        end
    endtask

    task automatic test_back_to_back();
        int exp_rises;
`ifdef SSP_TX_CONT_EN
        exp_rises = 1;
`else
        exp_rises = 2;
`endif
        clr();
        DSSPCLK = 4'd15;
        fifo.push_back(16'h8001);
        fifo.push_back(16'h7FFE);
        drive_fifo();
        for (int i = 0; i < 800 && done_cnt < 2; i++) step();
        vecs++;
        if (done_cnt != 2) begin
            errs++;
            $display("FAIL t2_done: got %0d expected 2", done_cnt);
        end
        vecs++;
        if (bitq.size() != 32 || packed_bits() !== 32'h8001_7FFE) begin
            errs++;
            $display("FAIL t2_bits: got %0d bits %h expected 32 bits 80017ffe", bitq.size(), packed_bits());
        end
        repeat (20) step();
        vecs++;
        if (pop_cnt != 2) begin
            errs++;
            $display("FAIL t2_pops: got %0d expected 2", pop_cnt);
        end
        vecs++;
        if (rise_cnt != exp_rises) begin
            errs++;
            $display("FAIL t2_fss_rises: got %0d expected %0d", rise_cnt, exp_rises);
        end
    endtask

    task automatic test_reserved_dss();
        bit fss_low;
        bit busy_seen;
        clr();
        fss_low = 1'b0;
        busy_seen = 1'b0;
        DSSPCLK = 4'd2;
        fifo.push_back(16'h1234);
        drive_fifo();
        for (int i = 0; i < 100; i++) begin
            step();
            if (SSPFSSOUT !== 1'b1) fss_low = 1'b1;
            if (TxBusy !== 1'b0) busy_seen = 1'b1;
        end
        vecs++;
        if (pop_cnt != 0) begin
            errs++;
            $display("FAIL t3_pops: got %0d expected 0", pop_cnt);
        end
        vecs++;
        if (fss_low) begin
            errs++;
            $display("FAIL t3_fss: got low at some cycle expected always 1");
        end
        vecs++;
        if (busy_seen) begin
            errs++;
            $display("FAIL t3_busy: got 1 at some cycle expected always 0");
        end
        fifo.delete();
        drive_fifo();
        step();
    endtask

    task automatic test_sse_abort();
        clr();
        DSSPCLK = 4'd11;
        fifo.push_back(16'hABC0);
        drive_fifo();
        for (int i = 0; i < 300 && strobes < 5; i++) step();
        step();
        SSE = 1'b0;
        step();
        vecs++;
        if ({SSPFSSOUT, SSPTXD, TxBusy} !== 3'b100) begin
            errs++;
            $display("FAIL t4_abort_outputs: fss/txd/busy got %b expected 100", {SSPFSSOUT, SSPTXD, TxBusy});
        end
        fifo.push_back(16'h1230);
        drive_fifo();
        repeat (60) step();
        vecs++;
        if (done_cnt != 0 || pop_cnt != 1) begin
            errs++;
            $display("FAIL t4_no_done_no_pop: done %0d pops %0d expected 0 1", done_cnt, pop_cnt);
        end
        fifo.delete();
        drive_fifo();
        step();
        SSE = 1'b1;
        step();
    endtask

    task automatic test_reset_midframe();
        clr();
        DSSPCLK = 4'd7;
        fifo.push_back(16'h3C00);
        fifo.push_back(16'hC300);
        drive_fifo();
        for (int i = 0; i < 300 && strobes < 3; i++) step();
        PRESET = 1'b1;
        step();
        vecs++;
        if ({TxFRd, SSPTXD, SSPFSSOUT, TxBusy, TxDone} !== 5'b00100) begin
            errs++;
            $display("FAIL t5_reset_outputs: got %b expected 00100", {TxFRd, SSPTXD, SSPFSSOUT, TxBusy, TxDone});
        end
        PRESET = 1'b0;
        bitq.delete();
        for (int i = 0; i < 300 && done_cnt == 0; i++) step();
        vecs++;
        if (bitq.size() != 8 || packed_bits() !== 32'h0000_00C3) begin
            errs++;
            $display("FAIL t5_restart_bits: got %0d bits %h expected 8 bits 000000c3", bitq.size(), packed_bits());
        end
        repeat (10) step();
        vecs++;
        if (pop_cnt != 2 || done_cnt != 1) begin
            errs++;
            $display("FAIL t5_counts: pops %0d done %0d expected 2 1", pop_cnt, done_cnt);
        end
    endtask

    task automatic test_short_frame_empty();
        clr();
        DSSPCLK = 4'd3;
        fifo.push_back(16'h9000);
        drive_fifo();
        for (int i = 0; i < 300 && done_cnt == 0; i++) step();
        vecs++;
        if ({SSPFSSOUT, TxBusy} !== 2'b11) begin
            errs++;
            $display("FAIL t6_gap: fss/busy got %b expected 11", {SSPFSSOUT, TxBusy});
        end
        vecs++;
        if (bitq.size() != 4 || packed_bits() !== 32'h0000_0009) begin
            errs++;
            $display("FAIL t6_bits: got %0d bits %h expected 4 bits 00000009", bitq.size(), packed_bits());
        end
        repeat (10) step();
        vecs++;
        if (pop_cnt != 1 || TxBusy !== 1'b0) begin
            errs++;
            $display("FAIL t6_idle: pops %0d busy %b expected 1 0", pop_cnt, TxBusy);
        end
    endtask

    task automatic test_dss_midframe();
        clr();
        DSSPCLK = 4'd7;
        fifo.push_back(16'h5A00);
        drive_fifo();
        for (int i = 0; i < 300 && strobes < 2; i++) step();
        DSSPCLK = 4'd15;
        for (int i = 0; i < 300 && done_cnt == 0; i++) step();
        vecs++;
        if (bitq.size() != 8 || packed_bits() !== 32'h0000_005A) begin
            errs++;
            $display("FAIL t7_dss_change: got %0d bits %h expected 8 bits 0000005a", bitq.size(), packed_bits());
        end
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reserved_dss();
        test_sse_abort();
        test_reset_midframe();
        test_short_frame_empty();
        test_dss_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
